// File: rtl/regfile_arbiter_pkg.sv
// Shared widths, register-file valid encodings and sequencer states for the
// register-file arbiter.
package regfile_arbiter_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 16;

  localparam logic [2:0] RF_VALID_NONE  = 3'b000;
  localparam logic [2:0] RF_VALID_READ  = 3'b011;
  localparam logic [2:0] RF_VALID_WRITE = 3'b100;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD1 = 2'd2;
  localparam logic [1:0] HOLD2 = 2'd3;

  function automatic logic [2:0] rf_valid_code(input logic we);
    return we ? RF_VALID_WRITE : RF_VALID_READ;
  endfunction

endpackage

// File: rtl/regfile_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the last-winner flop resets to B so that A
// takes the first tie.
module rr_arbiter2
  import regfile_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_b_q;
  logic last_b_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_b_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    last_b_d = last_b_q;
    if (|gnt) last_b_d = gnt[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_b_q <= 1'b1;
    else        last_b_q <= last_b_d;
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates requesters A and B onto the 32x16 register file and sequences
// its fixed three-edge access, returning read data or write completion.
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_ra1,
  input  logic [ADDR_W-1:0] a_ra2,
  input  logic [ADDR_W-1:0] a_wa,
  input  logic [DATA_W-1:0] a_wd,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_ra1,
  input  logic [ADDR_W-1:0] b_ra2,
  input  logic [ADDR_W-1:0] b_wa,
  input  logic [DATA_W-1:0] b_wd,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic [2:0]        rf_valid,
  output logic [ADDR_W-1:0] rf_read_addr_1,
  output logic [ADDR_W-1:0] rf_read_addr_2,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [DATA_W-1:0] rf_read_1,
  input  logic [DATA_W-1:0] rf_read_2,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rd1,
  output logic [DATA_W-1:0] rsp_rd2,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [1:0]        gnt;
  logic              arb_en;
  logic              any_gnt;

  logic              op_id_q, op_id_d;
  logic              op_we_q, op_we_d;
  logic [ADDR_W-1:0] op_ra1_q, op_ra1_d;
  logic [ADDR_W-1:0] op_ra2_q, op_ra2_d;
  logic [ADDR_W-1:0] op_wa_q, op_wa_d;
  logic [DATA_W-1:0] op_wd_q, op_wd_d;

  logic              rsp_pend_q, rsp_pend_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rsp_we_q, rsp_we_d;

  assign arb_en = (state_q == IDLE) || (state_q == HOLD2);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({b_req, a_req}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign a_gnt   = gnt[0];
  assign b_gnt   = gnt[1];
  assign any_gnt = |gnt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_gnt) state_d = ISSUE;
      ISSUE:   state_d = HOLD1;
      HOLD1:   state_d = HOLD2;
      HOLD2:   state_d = any_gnt ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Op registers drive the register file directly, so a grant in HOLD2 only
  // moves the rf lines after the current access has been sampled.
  always_comb begin
    op_id_d  = op_id_q;
    op_we_d  = op_we_q;
    op_ra1_d = op_ra1_q;
    op_ra2_d = op_ra2_q;
    op_wa_d  = op_wa_q;
    op_wd_d  = op_wd_q;
    if (any_gnt) begin
      op_id_d  = gnt[1];
      op_we_d  = gnt[1] ? b_we  : a_we;
      op_ra1_d = gnt[1] ? b_ra1 : a_ra1;
      op_ra2_d = gnt[1] ? b_ra2 : a_ra2;
      op_wa_d  = gnt[1] ? b_wa  : a_wa;
      op_wd_d  = gnt[1] ? b_wd  : a_wd;
    end
  end

  // Response identity is copied out in HOLD2 because the op registers may be
  // reloaded by a back-to-back grant on that same edge.
  always_comb begin
    rsp_pend_d = (state_q == HOLD2);
    rsp_id_d   = rsp_id_q;
    rsp_we_d   = rsp_we_q;
    if (state_q == HOLD2) begin
      rsp_id_d = op_id_q;
      rsp_we_d = op_we_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_id_q    <= 1'b0;
      op_we_q    <= 1'b0;
      op_ra1_q   <= '0;
      op_ra2_q   <= '0;
      op_wa_q    <= '0;
      op_wd_q    <= '0;
      rsp_pend_q <= 1'b0;
      rsp_id_q   <= 1'b0;
      rsp_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_id_q    <= op_id_d;
      op_we_q    <= op_we_d;
      op_ra1_q   <= op_ra1_d;
      op_ra2_q   <= op_ra2_d;
      op_wa_q    <= op_wa_d;
      op_wd_q    <= op_wd_d;
      rsp_pend_q <= rsp_pend_d;
      rsp_id_q   <= rsp_id_d;
      rsp_we_q   <= rsp_we_d;
    end
  end

  assign rf_valid       = (state_q == ISSUE) ? rf_valid_code(op_we_q) : RF_VALID_NONE;
  assign rf_read_addr_1 = op_ra1_q;
  assign rf_read_addr_2 = op_ra2_q;
  assign rf_write_addr  = op_wa_q;
  assign rf_write_data  = op_wd_q;
  assign busy           = (state_q != IDLE);

  assign rsp_valid = rsp_pend_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_rd1   = (rsp_pend_q && !rsp_we_q) ? rf_read_1 : '0;
  assign rsp_rd2   = (rsp_pend_q && !rsp_we_q) ? rf_read_2 : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus random traffic, with a
// behavioural register file and a transaction-level reference model.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0;
  logic [4:0]  a_ra1 = '0, a_ra2 = '0, a_wa = '0;
  logic [15:0] a_wd = '0;
  logic        b_req = 1'b0, b_we = 1'b0;
  logic [4:0]  b_ra1 = '0, b_ra2 = '0, b_wa = '0;
  logic [15:0] b_wd = '0;
  logic [15:0] rf_read_1 = '0, rf_read_2 = '0;

  logic        a_gnt, b_gnt, rsp_valid, rsp_id, rsp_we, busy;
  logic [2:0]  rf_valid;
  logic [4:0]  rf_read_addr_1, rf_read_addr_2, rf_write_addr;
  logic [15:0] rf_write_data, rsp_rd1, rsp_rd2;

  regfile_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_ra1(a_ra1), .a_ra2(a_ra2), .a_wa(a_wa), .a_wd(a_wd),
    .b_req(b_req), .b_we(b_we), .b_ra1(b_ra1), .b_ra2(b_ra2), .b_wa(b_wa), .b_wd(b_wd),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .rf_valid(rf_valid), .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .rf_read_1(rf_read_1), .rf_read_2(rf_read_2),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_we(rsp_we),
    .rsp_rd1(rsp_rd1), .rsp_rd2(rsp_rd2), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          g;
    bit          id;
    bit          we;
    logic [4:0]  ra1, ra2, wa;
    logic [15:0] wd;
  } op_s;

  typedef struct {
    bit          v;
    bit          we;
    logic [4:0]  ra1, ra2, wa;
    logic [15:0] wd;
  } rf_s;

  // Reference model: ops in grant order, architectural register contents.
  op_s         pend[$];
  op_s         vis;
  logic [15:0] mem_m [32];
  int          last_g;
  bit          last_win;

  // Behavioural register file: samples valid, acts two edges later.
  logic [15:0] mem_rf [32];
  rf_s         s1, s2, smp;

  int          cyc, checks, errors;
  bit          gA, gB, rnd_mode;
  int          gnt_cyc[$];
  bit          gnt_id[$];
  logic [15:0] rsp_rd1_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    vis      = '{g: 0, id: 1'b0, we: 1'b0, ra1: '0, ra2: '0, wa: '0, wd: '0};
    last_g   = -100;
    last_win = 1'b1;
  endtask

  task automatic reset_checks();
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    chk("rst_rf_valid", rf_valid, 0);
    chk("rst_ra1", rf_read_addr_1, 0);
    chk("rst_ra2", rf_read_addr_2, 0);
    chk("rst_wa", rf_write_addr, 0);
    chk("rst_wd", rf_write_data, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_we", rsp_we, 0);
    chk("rst_rsp_rd1", rsp_rd1, 0);
    chk("rst_rsp_rd2", rsp_rd2, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic rand_fields(output logic we, output logic [4:0] ra1, output logic [4:0] ra2,
                             output logic [4:0] wa, output logic [15:0] wd);
    we  = 1'($urandom_range(0, 1));
    ra1 = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    ra2 = 5'($urandom_range(0, 7));
    wa  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
    wd  = 16'($urandom);
  endtask

  // Compare every output for the current cycle, then advance the model.
  task automatic check_cycle();
    bit  can, ea, eb;
    op_s o;
    int  d;
    can = (cyc >= last_g + 3);
    ea  = can && a_req && (!b_req || last_win);
    eb  = can && b_req && (!a_req || !last_win);
    chk("a_gnt", a_gnt, ea);
    chk("b_gnt", b_gnt, eb);
    if (a_gnt || b_gnt) begin
      gnt_cyc.push_back(cyc);
      gnt_id.push_back(b_gnt);
    end
    chk("rf_valid", rf_valid, (last_g == cyc - 1) ? (vis.we ? 3'b100 : 3'b011) : 3'b000);
    chk("rf_read_addr_1", rf_read_addr_1, vis.ra1);
    chk("rf_read_addr_2", rf_read_addr_2, vis.ra2);
    chk("rf_write_addr", rf_write_addr, vis.wa);
    chk("rf_write_data", rf_write_data, vis.wd);
    d = cyc - last_g;
    chk("busy", busy, (d >= 1 && d <= 3));
    if (pend.size() > 0 && pend[0].g == cyc - 4) begin
      o = pend.pop_front();
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_id", rsp_id, o.id);
      chk("rsp_we", rsp_we, o.we);
      if (o.we) begin
        chk("rsp_rd1", rsp_rd1, 0);
        chk("rsp_rd2", rsp_rd2, 0);
        mem_m[o.wa] = o.wd;
      end else begin
        chk("rsp_rd1", rsp_rd1, mem_m[o.ra1]);
        chk("rsp_rd2", rsp_rd2, mem_m[o.ra2]);
      end
      rsp_rd1_log.push_back(rsp_rd1);
    end else begin
      chk("rsp_valid", rsp_valid, 0);
    end
    smp.v   = (rf_valid != 3'b000);
    smp.we  = (rf_valid == 3'b100);
    smp.ra1 = rf_read_addr_1;
    smp.ra2 = rf_read_addr_2;
    smp.wa  = rf_write_addr;
    smp.wd  = rf_write_data;
    if (ea || eb) begin
      o.g   = cyc;
      o.id  = eb;
      o.we  = eb ? b_we  : a_we;
      o.ra1 = eb ? b_ra1 : a_ra1;
      o.ra2 = eb ? b_ra2 : a_ra2;
      o.wa  = eb ? b_wa  : a_wa;
      o.wd  = eb ? b_wd  : a_wd;
      pend.push_back(o);
      vis      = o;
      last_g   = cyc;
      last_win = eb;
    end
    gA = ea;
    gB = eb;
  endtask

  task automatic rf_env_edge();
    if (s2.v) begin
      if (s2.we) mem_rf[s2.wa] = s2.wd;
      else begin
        rf_read_1 = mem_rf[s2.ra1];
        rf_read_2 = mem_rf[s2.ra2];
      end
    end
    s2 = s1;
    s1 = smp;
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    rf_env_edge();
    if (gA) a_req = 1'b0;
    if (gB) b_req = 1'b0;
    if (rnd_mode) begin
      if (!a_req && $urandom_range(0, 2) == 0) begin
        rand_fields(a_we, a_ra1, a_ra2, a_wa, a_wd);
        a_req = 1'b1;
      end
      if (!b_req && $urandom_range(0, 2) == 0) begin
        rand_fields(b_we, b_ra1, b_ra2, b_wa, b_wd);
        b_req = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int g0, na, nb, first;
    checks = 0;
    errors = 0;
    cyc = 0;
    rnd_mode = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mem_m[i]  = '0;
      mem_rf[i] = '0;
    end
    s1  = '{v: 1'b0, we: 1'b0, ra1: '0, ra2: '0, wa: '0, wd: '0};
    s2  = s1;
    smp = s1;
    model_reset();

    #2;
    reset_checks();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // A writes BEEF to r7.
    a_we = 1'b1; a_wa = 5'd7; a_wd = 16'hBEEF; a_ra1 = 5'd1; a_ra2 = 5'd2;
    a_req = 1'b1;
    g0 = cyc;
    run(6);
    chk("t1_gnt_cycle", gnt_cyc[0], g0);
    chk("t1_gnt_id", gnt_id[0], 0);

    // B reads r7, r3.
    b_we = 1'b0; b_ra1 = 5'd7; b_ra2 = 5'd3; b_wa = 5'd0; b_wd = 16'h0;
    b_req = 1'b1;
    run(6);
    chk("t2_rd1", rsp_rd1_log[$], 16'hBEEF);

    // Both request continuously for four ops each.
    na = 4; nb = 4;
    first = gnt_cyc.size();
    for (int k = 0; k < 60 && (na > 0 || nb > 0); k++) begin
      if (!a_req && na > 0) begin rand_fields(a_we, a_ra1, a_ra2, a_wa, a_wd); a_req = 1'b1; end
      if (!b_req && nb > 0) begin rand_fields(b_we, b_ra1, b_ra2, b_wa, b_wd); b_req = 1'b1; end
      tick();
      if (gA) na--;
      if (gB) nb--;
    end
    chk("tie_remaining", na + nb, 0);
    chk("tie_grants", gnt_cyc.size() - first, 8);
    if (gnt_cyc.size() >= first + 8) begin
      for (int k = 0; k < 8; k++) chk("tie_order", gnt_id[first + k], k % 2);
      for (int k = 1; k < 8; k++)
        chk("tie_spacing", gnt_cyc[first + k] - gnt_cyc[first + k - 1], 3);
    end
    run(6);

    // Back-to-back: A writes r5, B reads r5 granted in HOLD2.
    a_we = 1'b1; a_wa = 5'd5; a_wd = 16'h1234; a_ra1 = 5'd0; a_ra2 = 5'd0;
    a_req = 1'b1;
    tick();
    b_we = 1'b0; b_ra1 = 5'd5; b_ra2 = 5'd7; b_wa = 5'd0; b_wd = 16'h0;
    b_req = 1'b1;
    run(9);
    chk("b2b_rd1", rsp_rd1_log[$], 16'h1234);
    chk("b2b_spacing", gnt_cyc[$] - gnt_cyc[gnt_cyc.size() - 2], 3);

    // Request raised during HOLD1 waits for HOLD2.
    a_we = 1'b0; a_ra1 = 5'd5; a_ra2 = 5'd31;
    a_req = 1'b1;
    tick();
    tick();
    b_we = 1'b1; b_wa = 5'd9; b_wd = 16'hA5C3; b_ra1 = 5'd0; b_ra2 = 5'd0;
    b_req = 1'b1;
    run(9);
    chk("hold1_spacing", gnt_cyc[$] - gnt_cyc[gnt_cyc.size() - 2], 3);
    chk("hold1_id", gnt_id[$], 1);

    // Reset asserted during HOLD1 of a read.
    b_we = 1'b0; b_ra1 = 5'd5; b_ra2 = 5'd9;
    b_req = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    reset_checks();
    model_reset();
    tick();
    rst_n = 1'b1;
    rand_fields(a_we, a_ra1, a_ra2, a_wa, a_wd);
    rand_fields(b_we, b_ra1, b_ra2, b_wa, b_wd);
    a_req = 1'b1;
    b_req = 1'b1;
    g0 = cyc;
    run(10);
    chk("post_rst_gnt_cycle", gnt_cyc[gnt_cyc.size() - 2], g0);
    chk("post_rst_first_id", gnt_id[gnt_id.size() - 2], 0);

    // Random traffic.
    rnd_mode = 1'b1;
    run(300);
    rnd_mode = 1'b0;
    run(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Two-requester arbiter and sequencer for the 32x16 register file. Accepts whole read-pair or write operations from requesters A (decode/operand fetch) and B (writeback), grants one at a time round-robin, and drives the register file's valid/address/data lines stable for its fixed 3-edge access. Returns read data or write completion on a shared response port. Only this block drives the register file; it never re-asserts valid while an access is in flight.

## Interface
- ADDR_W, 5, register address width
- DATA_W, 16, register data width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req / b_req  in  1  operation request, held until granted
- a_we / b_we  in  1  1 = write, 0 = read pair
- a_ra1, a_ra2 / b_ra1, b_ra2  in  ADDR_W  read addresses
- a_wa / b_wa  in  ADDR_W  write address
- a_wd / b_wd  in  DATA_W  write data
- a_gnt / b_gnt  out  1  one-cycle grant; request fields captured on this edge
- rf_valid  out  3  to register file: 3'b011 read, 3'b100 write, else 0
- rf_read_addr_1, rf_read_addr_2, rf_write_addr  out  ADDR_W  to register file
- rf_write_data  out  DATA_W  to register file
- rf_read_1, rf_read_2  in  DATA_W  registered read data from register file
- rsp_valid  out  1  one-cycle completion strobe
- rsp_id  out  1  0 = A, 1 = B
- rsp_we  out  1  completed op was a write
- rsp_rd1, rsp_rd2  out  DATA_W  read data (0 for writes)
- busy  out  1  access in flight (ISSUE/HOLD1/HOLD2)

## Operation
- FSM: IDLE -> ISSUE -> HOLD1 -> HOLD2 -> (ISSUE if grant given in HOLD2, else IDLE).
- Arbitration in IDLE and HOLD2 only. One requester: it wins. Both: winner is the one not granted last; last-winner register resets to B, so A wins the first tie.
- Grant cycle G: x_gnt=1, op fields latched into op registers at end of G.
- ISSUE (G+1): rf_valid = we ? 3'b100 : 3'b011, one cycle only. Addresses/data from op registers, held unchanged through HOLD2.
- Register file samples valid at end of G+1, writes/updates read outputs at end of G+3.
- Cycle G+4: rsp_valid=1, rsp_id/rsp_we from op registers; for reads rsp_rd1/rd2 = rf_read_1/rf_read_2 (combinational pass-through, register file outputs are registered); for writes rsp_rd1/rd2 = 0. Write is already visible to a read issued at G+4 or later.
- Next op may be granted in HOLD2 (G+3) and issue at G+4; rf addresses change only from G+4, after the register file sampled them. Sustained throughput: one op per 3 cycles.
- No request queuing; requesters hold req and fields until gnt, then may drop req or present a new op the next cycle.
- No write-to-register-0 protection; register 0 is an ordinary register.

## Timing
- Reset values: a_gnt=b_gnt=0, rf_valid=0, all rf address/data outputs 0, rsp_valid=0, rsp_id=0, rsp_we=0, rsp_rd1=rsp_rd2=0, busy=0, FSM=IDLE.
- Request-to-grant: 0 cycles from IDLE (grant combinational from req + state + last-winner, registered nowhere else).
- Grant-to-response: 4 cycles. rf_valid high exactly 1 cycle per op; never high in HOLD1/HOLD2/IDLE.
- req asserted during ISSUE/HOLD1: no grant until HOLD2.
- Both requests continuously asserted: grants alternate A, B, A, B every 3 cycles.
- Reset mid-op: FSM to IDLE, rsp suppressed. Register file has no reset, so a write issued before reset may still land; requesters must reissue after reset.
- rf outputs in IDLE hold last issued values.

## Structure
- Shared package: ADDR_W, DATA_W, rf_valid encodings (RF_VALID_READ=3'b011, RF_VALID_WRITE=3'b100, RF_VALID_NONE), FSM state enum (IDLE, ISSUE, HOLD1, HOLD2).
- One natural sub-module: rr_arbiter2 (2-way round-robin, inputs req[1:0], enable; outputs gnt[1:0]; owns last-winner register).

## Test plan
- Reset, A writes 16'hBEEF to r7 -> a_gnt at G, rf_valid=3'b100 at G+1 only, rsp_valid/rsp_id=0/rsp_we=1 at G+4.
- Then B reads r7, r3 -> rsp at G+4 with rsp_id=1, rsp_rd1=16'hBEEF, rsp_rd2=0.
- A and B request simultaneously for 4 ops each -> grant order A,B,A,B at 3-cycle spacing, rf_valid never asserted in consecutive cycles.
- Back-to-back: A write r5=16'h1234 granted, B read r5 granted in HOLD2 -> B's rsp_rd1=16'h1234, rf_read_addr_1=5 not driven before G+4.
- Request raised during HOLD1 -> grant delayed to HOLD2; rf addresses unchanged through HOLD2.
- rst_n low during HOLD1 of a read -> outputs at reset values asynchronously, no rsp_valid; next request after release granted immediately with A winning a tie.
